// File: rtl/rot_pipe_pkg.sv
// Shared types and helpers for the pipelined rotator/shifter rot_pipe.
package rot_pipe_pkg;

  typedef enum logic [1:0] {
    ROT_R = 2'b00,
    ROT_L = 2'b01,
    SHR   = 2'b10,
    SHL   = 2'b11
  } rot_mode_e;

  // Displacement applied by log stage i of an n-bit rotator.
  function automatic int stage_shift(input int n, input int i);
    return n >> (i + 1);
  endfunction

endpackage

// File: rtl/rot_pipe_stage.sv
// One log stage of rot_pipe: a fixed displacement gated by k[IDX], then a register.
// ROT_PIPE_TAG_EN adds a sideband tag register that follows the word.
module rot_pipe_stage
  import rot_pipe_pkg::*;
#(
  parameter int N      = 256,
  parameter int LOG2_N = 8,
  parameter int IDX    = 0
`ifdef ROT_PIPE_TAG_EN
  , parameter int TAG_W = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  input  logic [0:N-1]      up_bits,
  input  logic [0:LOG2_N-1] up_k,
  input  rot_mode_e         up_mode,
`ifdef ROT_PIPE_TAG_EN
  input  logic [TAG_W-1:0]  up_tag,
  output logic [TAG_W-1:0]  tag,
`endif
  input  logic              down_advance,
  output logic              valid,
  output logic [0:N-1]      bits,
  output logic [0:LOG2_N-1] k,
  output rot_mode_e         mode
);

  localparam int D = stage_shift(N, IDX);

  logic [0:N-1] rot_r, rot_l, shr, shl, moved;
  logic         advance;

  for (genvar j = 0; j < N; j++) begin : g_bit
    assign rot_r[j] = up_bits[(j - D + N) % N];
    assign rot_l[j] = up_bits[(j + D) % N];
    if (j >= D) begin : g_shr_in
      assign shr[j] = up_bits[j - D];
    end else begin : g_shr_zero
      assign shr[j] = 1'b0;
    end
    if (j + D < N) begin : g_shl_in
      assign shl[j] = up_bits[j + D];
    end else begin : g_shl_zero
      assign shl[j] = 1'b0;
    end
  end

  always_comb begin
    moved = up_bits;
    if (up_k[IDX]) begin
      case (up_mode)
        ROT_R:   moved = rot_r;
        ROT_L:   moved = rot_l;
        SHR:     moved = shr;
        SHL:     moved = shl;
        default: moved = up_bits;
      endcase
    end
  end

  assign advance = !valid || down_advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      bits  <= '0;
      k     <= '0;
      mode  <= ROT_R;
`ifdef ROT_PIPE_TAG_EN
      tag   <= '0;
`endif
    end else if (advance) begin
      valid <= up_valid;
      if (up_valid) begin
        bits <= moved;
        k    <= up_k;
        mode <= up_mode;
`ifdef ROT_PIPE_TAG_EN
        tag  <= up_tag;
`endif
      end
    end
  end

endmodule

// File: rtl/rot_pipe.sv
// Pipelined N-bit rotator/shifter, one registered log stage per amount bit.
// Define ROT_PIPE_TAG_EN to carry an in_tag/out_tag sideband with each word.
module rot_pipe
  import rot_pipe_pkg::*;
#(
  parameter int N      = 256,
  parameter int LOG2_N = 8,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:N-1]      in_bits,
  input  logic [0:LOG2_N-1] in_k,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:N-1]      out_bits
`ifdef ROT_PIPE_TAG_EN
  , input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0]   out_tag
`endif
);

  // Handshake: a word moves when valid && ready; a stage loads when it is
  // empty or its successor moves, so bubbles collapse behind a stalled output.

  if (N != (1 << LOG2_N) || LOG2_N < 1 || TAG_W < 1) begin : g_bad_params
    $error("rot_pipe: N must equal 2**LOG2_N, LOG2_N >= 1, TAG_W >= 1");
  end

  logic              v_c    [0:LOG2_N];
  logic [0:N-1]      bits_c [0:LOG2_N];
  logic [0:LOG2_N-1] k_c    [0:LOG2_N];
  rot_mode_e         mode_c [0:LOG2_N];
  logic [0:LOG2_N-1] down_adv;
  logic              unused_tail;

  assign v_c[0]    = in_valid;
  assign bits_c[0] = in_bits;
  assign k_c[0]    = in_k;
  assign mode_c[0] = rot_mode_e'(in_mode);

`ifdef ROT_PIPE_TAG_EN
  logic [TAG_W-1:0] tag_c [0:LOG2_N];
  assign tag_c[0] = in_tag;
  assign out_tag  = tag_c[LOG2_N];
`endif

  // Walk back from the output: a stage may release when every later stage is
  // able to move, i.e. out_ready or some later stage is empty.
  always_comb begin
    logic run;
    run      = out_ready;
    down_adv = '0;
    for (int i = LOG2_N - 1; i >= 0; i--) begin
      down_adv[i] = run;
      run         = run | ~v_c[i+1];
    end
    in_ready = run && !rst;
  end

  for (genvar i = 0; i < LOG2_N; i++) begin : g_stage
    rot_pipe_stage #(
      .N      (N),
      .LOG2_N (LOG2_N),
      .IDX    (i)
`ifdef ROT_PIPE_TAG_EN
      , .TAG_W (TAG_W)
`endif
    ) u_stage (
      .clk          (clk),
      .rst          (rst),
      .up_valid     (v_c[i]),
      .up_bits      (bits_c[i]),
      .up_k         (k_c[i]),
      .up_mode      (mode_c[i]),
`ifdef ROT_PIPE_TAG_EN
      .up_tag       (tag_c[i]),
      .tag          (tag_c[i+1]),
`endif
      .down_advance (down_adv[i]),
      .valid        (v_c[i+1]),
      .bits         (bits_c[i+1]),
      .k            (k_c[i+1]),
      .mode         (mode_c[i+1])
    );
  end

  assign out_valid   = v_c[LOG2_N];
  assign out_bits    = bits_c[LOG2_N];
  assign unused_tail = ^{k_c[LOG2_N], mode_c[LOG2_N]};

endmodule

// File: tb/tb_rot_pipe.sv
// Self-checking bench for rot_pipe at N=8 with a whole-amount reference model.
// Build with ROT_PIPE_TAG_EN defined to also check the tag sideband.
module tb_rot_pipe;

  localparam int N      = 8;
  localparam int LOG2_N = 3;
  localparam int TAG_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [0:N-1]      in_bits;
  logic [0:LOG2_N-1] in_k;
  logic [1:0]        in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [0:N-1]      out_bits;
`ifdef ROT_PIPE_TAG_EN
  logic [TAG_W-1:0]  out_tag;
`endif

  rot_pipe #(.N(N), .LOG2_N(LOG2_N), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .in_k      (in_k),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits)
`ifdef ROT_PIPE_TAG_EN
    , .in_tag  (in_tag),
    .out_tag   (out_tag)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [0:N-1] ref_fn(input logic [0:N-1] b, input logic [0:LOG2_N-1] k,
                                          input logic [1:0] m);
    logic [0:N-1] r;
    int s;
    s = int'(k);
    for (int j = 0; j < N; j++) begin
      case (m)
        2'b00:   r[j] = b[(j - s + N) % N];
        2'b01:   r[j] = b[(j + s) % N];
        2'b10:   r[j] = (j >= s) ? b[j - s] : 1'b0;
        default: r[j] = (j + s < N) ? b[j + s] : 1'b0;
      endcase
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [N-1:0]     exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  int               out_cyc_q[$];
  int checks  = 0;
  int passed  = 0;
  int out_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_tag_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        out_cnt++;
        out_cyc_q.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_output: got %b, required no output", out_bits);
        end else begin
          if (out_bits === exp_q[0]) passed++;
          else $display("FAIL out_bits: got %b, required %b", out_bits, exp_q[0]);
`ifdef ROT_PIPE_TAG_EN
          checks++;
          if (out_tag === exp_tag_q[0]) passed++;
          else $display("FAIL out_tag: got %h, required %h", out_tag, exp_tag_q[0]);
`endif
          void'(exp_q.pop_front());
          void'(exp_tag_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_fn(in_bits, in_k, in_mode));
        exp_tag_q.push_back(in_tag);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called and returning at posedge+1; offers one word until accepted or budget runs out.
  task automatic send(input logic [0:N-1] b, input logic [0:LOG2_N-1] k, input logic [1:0] m,
                      input logic [TAG_W-1:0] t, input int budget, output bit ok);
    in_valid = 1'b1;
    in_bits  = b;
    in_k     = k;
    in_mode  = m;
    in_tag   = t;
    ok       = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: %0d words still outstanding, required 0", exp_q.size());
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_bits   = 8'hA5;
    in_k      = 3'd2;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (in_ready === 1'b0) passed++;
    else $display("FAIL reset_in_ready: got %b, required 0", in_ready);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid === 1'b0) passed++;
    else $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    checks++;
    if (out_bits === 8'h00) passed++;
    else $display("FAIL reset_out_bits: got %b, required 00000000", out_bits);
    checks++;
    if (in_ready === 1'b1) passed++;
    else $display("FAIL reset_release_in_ready: got %b, required 1", in_ready);
    @(posedge clk);
    #1;
  endtask

  task automatic test_modes();
    logic [1:0]        t_mode [7];
    logic [0:LOG2_N-1] t_k    [7];
    logic [0:N-1]      t_in   [7];
    logic [0:N-1]      t_out  [7];
    bit ok, got;
    int lat;
    t_mode[0] = 2'b00; t_k[0] = 3'b001; t_in[0] = 8'b1000_0001; t_out[0] = 8'b1100_0000;
    t_mode[1] = 2'b01; t_k[1] = 3'b001; t_in[1] = 8'b1000_0001; t_out[1] = 8'b0000_0011;
    t_mode[2] = 2'b10; t_k[2] = 3'b011; t_in[2] = 8'b1111_0000; t_out[2] = 8'b0001_1110;
    t_mode[3] = 2'b11; t_k[3] = 3'b011; t_in[3] = 8'b0000_1111; t_out[3] = 8'b0111_1000;
    t_mode[4] = 2'b01; t_k[4] = 3'b000; t_in[4] = 8'b1011_0010; t_out[4] = 8'b1011_0010;
    t_mode[5] = 2'b10; t_k[5] = 3'b111; t_in[5] = 8'b1010_1011; t_out[5] = 8'b0000_0001;
    t_mode[6] = 2'b11; t_k[6] = 3'b111; t_in[6] = 8'b1101_0101; t_out[6] = 8'b1000_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(t_in[i], t_k[i], t_mode[i], 8'h00, 4, ok);
      lat = 1;
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (out_valid) got = 1'b1;
        else begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
      checks++;
      if (ok && got && lat == LOG2_N) passed++;
      else $display("FAIL mode_latency[%0d]: accepted=%0b seen=%0b latency %0d, required %0d",
                    i, ok, got, lat, LOG2_N);
      checks++;
      if (out_bits === t_out[i]) passed++;
      else $display("FAIL mode_result[%0d]: got %b, required %b", i, out_bits, t_out[i]);
      @(posedge clk);
      #1;
    end
    drain(10);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n_ok = 0;
    out_ready = 1'b1;
    out_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      send(N'($urandom), LOG2_N'($urandom_range(0, N - 1)), 2'(i % 4), 8'h00, 1, ok);
      if (ok) n_ok++;
    end
    checks++;
    if (n_ok == 8) passed++;
    else $display("FAIL b2b_accept: got %0d single-cycle accepts, required 8", n_ok);
    drain(20);
    checks++;
    if (out_cyc_q.size() == 8 && out_cyc_q[7] - out_cyc_q[0] == 7) passed++;
    else $display("FAIL b2b_consecutive: got %0d results over span %0d, required 8 over 7",
                  out_cyc_q.size(), (out_cyc_q.size() > 0) ? out_cyc_q[$] - out_cyc_q[0] : -1);
  endtask

  task automatic test_stall();
    logic [0:N-1] wb [5];
    logic [0:N-1] held;
    bit have, ok;
    int idx, acc, bad, base;
    for (int i = 0; i < 5; i++) wb[i] = N'($urandom);
    idx = 0; acc = 0; bad = 0; have = 1'b0; held = '0;
    base = out_cnt;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_bits  = wb[idx];
      in_k     = LOG2_N'(idx + 1);
      in_mode  = 2'(idx % 4);
      in_tag   = 8'h00;
      @(negedge clk);
      if (out_valid) begin
        if (!have) begin
          held = out_bits;
          have = 1'b1;
        end else if (out_bits !== held) bad++;
      end
      if (in_ready) begin
        acc++;
        idx++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (acc == 3) passed++;
    else $display("FAIL stall_accepted: got %0d, required 3", acc);
    checks++;
    if (in_ready === 1'b0) passed++;
    else $display("FAIL stall_in_ready: got %b, required 0", in_ready);
    checks++;
    if (have && bad == 0) passed++;
    else $display("FAIL stall_hold: out_valid seen=%0b, changes %0d, required 1 and 0", have, bad);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    while (idx < 5) begin
      send(wb[idx], LOG2_N'(idx + 1), 2'(idx % 4), 8'h00, 10, ok);
      idx++;
    end
    drain(20);
    checks++;
    if (out_cnt - base == 5) passed++;
    else $display("FAIL stall_count: got %0d results, required 5", out_cnt - base);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    out_ready = 1'b1;
    send(8'b1100_1010, 3'd1, 2'b00, 8'h00, 2, ok);
    send(8'b0011_0110, 3'd2, 2'b11, 8'h00, 2, ok);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_bits  = 8'hFF;
    @(negedge clk);
    checks++;
    if (in_ready === 1'b0) passed++;
    else $display("FAIL midrst_in_ready: got %b, required 0", in_ready);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    base     = out_cnt;
    @(negedge clk);
    checks++;
    if (out_valid === 1'b0 && out_bits === 8'h00) passed++;
    else $display("FAIL midrst_out: got valid %b bits %b, required 0 and 00000000",
                  out_valid, out_bits);
    checks++;
    if (in_ready === 1'b1) passed++;
    else $display("FAIL midrst_release: got in_ready %b, required 1", in_ready);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (out_cnt == base) passed++;
    else $display("FAIL midrst_discard: got %0d results, required 0", out_cnt - base);
  endtask

  task automatic test_random_stall();
    int acc, base;
    base = out_cnt;
    acc  = 0;
    for (int c = 0; c < 200 && acc < 8; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'b1;
      in_bits   = N'($urandom);
      in_k      = LOG2_N'($urandom_range(0, N - 1));
      in_mode   = 2'($urandom_range(0, 3));
      in_tag    = TAG_W'(8'h11 + acc);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (acc == 8) passed++;
    else $display("FAIL random_accept: got %0d, required 8", acc);
    drain(20);
    checks++;
    if (out_cnt - base == 8) passed++;
    else $display("FAIL random_count: got %0d results, required 8", out_cnt - base);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bits   = '0;
    in_k      = '0;
    in_mode   = 2'b00;
    in_tag    = '0;
    out_ready = 1'b1;
    test_reset();
    test_modes();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random_stall();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
